// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per clock, RISC-V signed/unsigned
// semantics, with divide-by-zero and signed overflow answered without iterating.
`ifndef XLEN
`define XLEN 64
`endif

module div_unit #(
  parameter int WIDTH = `XLEN
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iFlush,
  input  logic             iReqValid,
  output logic             oReqReady,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  input  logic             iSigned,
  output logic             oRespValid,
  input  logic             iRespReady,
  output logic [WIDTH-1:0] oQuot,
  output logic [WIDTH-1:0] oRem,
  output logic [1:0]       dbg_state
);

  // Handshake: a request transfers on an edge where iReqValid && oReqReady && !iFlush;
  // a response transfers on an edge where oRespValid && iRespReady. Both ready/valid
  // outputs come from registered state only.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_next;

  logic [WIDTH-1:0] dividend_shift;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] divisor_mag;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    count;

  logic             accept;
  logic             div_zero;
  logic             sign_ovf;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;
  logic             last_step;

  assign min_val  = {1'b1, {(WIDTH-1){1'b0}}};
  assign accept   = iReqValid && (state == IDLE) && !iFlush;
  assign div_zero = (iDivisor == '0);
  assign sign_ovf = iSigned && (iDividend == min_val) && (iDivisor == '1);
  assign dvd_mag  = (iSigned && iDividend[WIDTH-1]) ? -iDividend : iDividend;
  assign dvs_mag  = (iSigned && iDivisor[WIDTH-1])  ? -iDivisor  : iDivisor;

  // The shifted partial remainder can exceed WIDTH bits, so the trial keeps one extra bit.
  assign shifted   = {part_rem, dividend_shift[WIDTH-1]};
  assign trial     = shifted - {1'b0, divisor_mag};
  assign q_bit     = ~trial[WIDTH];
  assign rem_step  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_step = {dividend_shift[WIDTH-2:0], q_bit};
  assign last_step = (count == CW'(WIDTH - 1));

  assign oReqReady  = (state == IDLE);
  assign oRespValid = (state == DONE);
  assign dbg_state  = state;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (iReqValid) state_next = (div_zero || sign_ovf) ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (iRespReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (iFlush) state_next = IDLE;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      dividend_shift <= '0;
      part_rem       <= '0;
      divisor_mag    <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      count          <= '0;
      oQuot          <= '0;
      oRem           <= '0;
    end else if (accept) begin
      if (div_zero) begin
        oQuot <= '1;
        oRem  <= iDividend;
      end else if (sign_ovf) begin
        oQuot <= iDividend;
        oRem  <= '0;
      end else begin
        dividend_shift <= dvd_mag;
        divisor_mag    <= dvs_mag;
        neg_q          <= iSigned & (iDividend[WIDTH-1] ^ iDivisor[WIDTH-1]);
        neg_r          <= iSigned & iDividend[WIDTH-1];
        part_rem       <= '0;
        count          <= '0;
      end
    end else if ((state == CALC) && !iFlush) begin
      dividend_shift <= quot_step;
      part_rem       <= rem_step;
      count          <= count + CW'(1);
      // The final step also applies the sign correction to the result registers.
      if (last_step) begin
        oQuot <= neg_q ? -quot_step : quot_step;
        oRem  <= neg_r ? -rem_step  : rem_step;
      end
    end
  end

endmodule
